// File: rtl/id_ex_mem_control_pkg.sv
// Shared definitions for the decode-stage control block and its ID/EX and
// EX/MEM pipeline registers: opcode values, ALU operation codes, immediate
// format encodings, the decoded control bundle and the default datapath width.
package id_ex_mem_control_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;

  typedef enum logic [5:0] {
    OP_NOP  = 6'h00,
    OP_ADD  = 6'h01,
    OP_SUB  = 6'h02,
    OP_AND  = 6'h03,
    OP_OR   = 6'h04,
    OP_XOR  = 6'h05,
    OP_SLL  = 6'h06,
    OP_SRL  = 6'h07,
    OP_MUL  = 6'h08,
    OP_ADDI = 6'h10,
    OP_SUBI = 6'h11,
    OP_MOVI = 6'h12,
    OP_LDR  = 6'h20,
    OP_STR  = 6'h21,
    OP_B    = 6'h30
  } opcode_e;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_AND   = 5'd2,
    ALU_OR    = 5'd3,
    ALU_XOR   = 5'd4,
    ALU_SLL   = 5'd5,
    ALU_SRL   = 5'd6,
    ALU_MUL   = 5'd7,
    ALU_PASSB = 5'd8
  } alu_op_e;

  typedef enum logic [1:0] {
    IMM_10 = 2'd0,
    IMM_15 = 2'd1,
    IMM_20 = 2'd2
  } imm_src_e;

  // Control bits that travel down the pipeline with the instruction.
  typedef struct packed {
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [4:0] alu_control;
  } ctrl_t;

endpackage

// File: rtl/id_ex_mem_control_decoder.sv
// control_decoder: purely combinational opcode decoder.
// Ports:
//   opcode  - 6-bit decode-stage opcode
//   pc_src  - branch-taken select
//   imm_src - immediate format (0 imm10, 1 imm15, 2 imm20)
//   ctrl    - control bundle registered into ID/EX
// Unlisted opcodes decode exactly as NOP.
module control_decoder
  import id_ex_mem_control_pkg::*;
(
  input  logic [5:0] opcode,
  output logic       pc_src,
  output logic [1:0] imm_src,
  output ctrl_t      ctrl
);

  always_comb begin
    pc_src  = 1'b0;
    imm_src = '0;
    ctrl    = '0;
    case (opcode)
      OP_ADD: begin ctrl.reg_write = 1'b1; ctrl.alu_control = ALU_ADD; end
      OP_SUB: begin ctrl.reg_write = 1'b1; ctrl.alu_control = ALU_SUB; end
      OP_AND: begin ctrl.reg_write = 1'b1; ctrl.alu_control = ALU_AND; end
      OP_OR:  begin ctrl.reg_write = 1'b1; ctrl.alu_control = ALU_OR;  end
      OP_XOR: begin ctrl.reg_write = 1'b1; ctrl.alu_control = ALU_XOR; end
      OP_SLL: begin ctrl.reg_write = 1'b1; ctrl.alu_control = ALU_SLL; end
      OP_SRL: begin ctrl.reg_write = 1'b1; ctrl.alu_control = ALU_SRL; end
      OP_MUL: begin ctrl.reg_write = 1'b1; ctrl.alu_control = ALU_MUL; end
      OP_ADDI: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        imm_src          = IMM_10;
        ctrl.alu_control = ALU_ADD;
      end
      OP_SUBI: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        imm_src          = IMM_10;
        ctrl.alu_control = ALU_SUB;
      end
      OP_MOVI: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        imm_src          = IMM_20;
        ctrl.alu_control = ALU_PASSB;
      end
      OP_LDR: begin
        ctrl.mem_to_reg  = 1'b1;
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        imm_src          = IMM_15;
        ctrl.alu_control = ALU_ADD;
      end
      OP_STR: begin
        ctrl.mem_write   = 1'b1;
        ctrl.alu_src     = 1'b1;
        imm_src          = IMM_15;
        ctrl.alu_control = ALU_ADD;
      end
      OP_B: begin
        pc_src  = 1'b1;
        imm_src = IMM_20;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_ex_mem_control.sv
// id_ex_mem_control: decode-stage control plus ID/EX and EX/MEM registers.
// Ports:
//   clk, rst (async, active-low)
//   opcode, id_*           - decode-stage inputs
//   pc_src, imm_src        - combinational decode outputs (reset-independent)
//   ex_*                   - ID/EX register outputs
//   ex_alu_result, ex_store_data - execute-stage inputs to EX/MEM
//   mem_*                  - EX/MEM register outputs
//   flush                  - only with PIPE_FLUSH_EN: zeroes ID/EX control bits
// Optional feature macro: PIPE_FLUSH_EN.
module id_ex_mem_control
  import id_ex_mem_control_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        opcode,
  input  logic [DATA_W-1:0] id_pc_count,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_sign_imm,
  input  logic [4:0]        id_rd,
  output logic              pc_src,
  output logic [1:0]        imm_src,
  output logic              ex_mem_to_reg,
  output logic              ex_mem_write,
  output logic              ex_alu_src,
  output logic              ex_reg_write,
  output logic [4:0]        ex_alu_control,
  output logic [DATA_W-1:0] ex_pc_count,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_sign_imm,
  output logic [4:0]        ex_rd,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  output logic              mem_mem_to_reg,
  output logic              mem_mem_write,
  output logic              mem_reg_write,
  output logic [DATA_W-1:0] mem_pc_count,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [4:0]        mem_rd
`ifdef PIPE_FLUSH_EN
  ,
  input  logic              flush
`endif
);

  ctrl_t dec_ctrl;
  ctrl_t id_ex_ctrl;
  ctrl_t next_ctrl;

  control_decoder u_decoder (
    .opcode  (opcode),
    .pc_src  (pc_src),
    .imm_src (imm_src),
    .ctrl    (dec_ctrl)
  );

  // Flush squashes only the control bits; data fields still advance.
`ifdef PIPE_FLUSH_EN
  assign next_ctrl = flush ? '0 : dec_ctrl;
`else
  assign next_ctrl = dec_ctrl;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_ex_ctrl  <= '0;
      ex_pc_count <= '0;
      ex_rd1      <= '0;
      ex_rd2      <= '0;
      ex_sign_imm <= '0;
      ex_rd       <= '0;
    end else begin
      id_ex_ctrl  <= next_ctrl;
      ex_pc_count <= id_pc_count;
      ex_rd1      <= id_rd1;
      ex_rd2      <= id_rd2;
      ex_sign_imm <= id_sign_imm;
      ex_rd       <= id_rd;
    end
  end

  assign ex_mem_to_reg  = id_ex_ctrl.mem_to_reg;
  assign ex_mem_write   = id_ex_ctrl.mem_write;
  assign ex_alu_src     = id_ex_ctrl.alu_src;
  assign ex_reg_write   = id_ex_ctrl.reg_write;
  assign ex_alu_control = id_ex_ctrl.alu_control;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_mem_to_reg <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_reg_write  <= 1'b0;
      mem_pc_count   <= '0;
      mem_alu_result <= '0;
      mem_store_data <= '0;
      mem_rd         <= '0;
    end else begin
      mem_mem_to_reg <= ex_mem_to_reg;
      mem_mem_write  <= ex_mem_write;
      mem_reg_write  <= ex_reg_write;
      mem_pc_count   <= ex_pc_count;
      mem_alu_result <= ex_alu_result;
      mem_store_data <= ex_store_data;
      mem_rd         <= ex_rd;
    end
  end

endmodule

// File: tb/tb_id_ex_mem_control.sv
// Directed testbench for id_ex_mem_control. Build with +define+PIPE_FLUSH_EN
// to include the flush checks.
module tb_id_ex_mem_control;

  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic [5:0]    opcode;
  logic [DW-1:0] id_pc_count, id_rd1, id_rd2, id_sign_imm;
  logic [4:0]    id_rd;
  logic          pc_src;
  logic [1:0]    imm_src;
  logic          ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write;
  logic [4:0]    ex_alu_control;
  logic [DW-1:0] ex_pc_count, ex_rd1, ex_rd2, ex_sign_imm;
  logic [4:0]    ex_rd;
  logic [DW-1:0] ex_alu_result, ex_store_data;
  logic          mem_mem_to_reg, mem_mem_write, mem_reg_write;
  logic [DW-1:0] mem_pc_count, mem_alu_result, mem_store_data;
  logic [4:0]    mem_rd;
`ifdef PIPE_FLUSH_EN
  logic          flush;
`endif

  int checks = 0;
  int errors = 0;

  id_ex_mem_control #(.DATA_W(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .opcode         (opcode),
    .id_pc_count    (id_pc_count),
    .id_rd1         (id_rd1),
    .id_rd2         (id_rd2),
    .id_sign_imm    (id_sign_imm),
    .id_rd          (id_rd),
    .pc_src         (pc_src),
    .imm_src        (imm_src),
    .ex_mem_to_reg  (ex_mem_to_reg),
    .ex_mem_write   (ex_mem_write),
    .ex_alu_src     (ex_alu_src),
    .ex_reg_write   (ex_reg_write),
    .ex_alu_control (ex_alu_control),
    .ex_pc_count    (ex_pc_count),
    .ex_rd1         (ex_rd1),
    .ex_rd2         (ex_rd2),
    .ex_sign_imm    (ex_sign_imm),
    .ex_rd          (ex_rd),
    .ex_alu_result  (ex_alu_result),
    .ex_store_data  (ex_store_data),
    .mem_mem_to_reg (mem_mem_to_reg),
    .mem_mem_write  (mem_mem_write),
    .mem_reg_write  (mem_reg_write),
    .mem_pc_count   (mem_pc_count),
    .mem_alu_result (mem_alu_result),
    .mem_store_data (mem_store_data),
    .mem_rd         (mem_rd)
`ifdef PIPE_FLUSH_EN
    ,
    .flush          (flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [5:0] op;
    logic       ps;
    logic [1:0] is;
    logic       m2r;
    logic       mw;
    logic       as;
    logic       rw;
    logic [4:0] alu;
  } vec_t;

  vec_t vecs[16];

  task automatic check_all_regs_zero(input string tag);
    logic [31:0] orv;
    orv = 32'(ex_mem_to_reg) | 32'(ex_mem_write) | 32'(ex_alu_src) | 32'(ex_reg_write)
        | 32'(ex_alu_control) | ex_pc_count | ex_rd1 | ex_rd2 | ex_sign_imm | 32'(ex_rd)
        | 32'(mem_mem_to_reg) | 32'(mem_mem_write) | 32'(mem_reg_write)
        | mem_pc_count | mem_alu_result | mem_store_data | 32'(mem_rd);
    check(tag, orv, 32'h0);
  endtask

  initial begin
    vecs[0]  = '{6'h01, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0};
    vecs[1]  = '{6'h02, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1};
    vecs[2]  = '{6'h03, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2};
    vecs[3]  = '{6'h04, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3};
    vecs[4]  = '{6'h05, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4};
    vecs[5]  = '{6'h06, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5};
    vecs[6]  = '{6'h07, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6};
    vecs[7]  = '{6'h08, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7};
    vecs[8]  = '{6'h10, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0};
    vecs[9]  = '{6'h11, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1};
    vecs[10] = '{6'h12, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8};
    vecs[11] = '{6'h3F, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[12] = '{6'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[13] = '{6'h09, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[14] = '{6'h22, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[15] = '{6'h31, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};

    // Asynchronous reset with busy inputs, before any clock edge.
    rst           = 1'b1;
    opcode        = 6'h30;
    id_pc_count   = 32'h0000_0AAA;
    id_rd1        = 32'h1111_1111;
    id_rd2        = 32'h2222_2222;
    id_sign_imm   = 32'h3333_3333;
    id_rd         = 5'd31;
    ex_alu_result = 32'h4444_4444;
    ex_store_data = 32'h5555_5555;
`ifdef PIPE_FLUSH_EN
    flush         = 1'b0;
`endif
    #1 rst = 1'b0;
    #1;
    check_all_regs_zero("async_reset");
    check("pc_src_in_reset", 32'(pc_src), 32'd1);
    check("imm_src_in_reset", 32'(imm_src), 32'd2);
    tick();
    check_all_regs_zero("reset_hold");

    // Release between edges; LDR enters decode.
    #3 rst = 1'b1;
    opcode      = 6'h20;
    id_pc_count = 32'h0000_0100;
    id_rd1      = 32'h0000_0011;
    id_rd2      = 32'h0000_0022;
    id_sign_imm = 32'h0000_0010;
    id_rd       = 5'd5;
    #1;
    check("ldr_pc_src", 32'(pc_src), 32'd0);
    check("ldr_imm_src", 32'(imm_src), 32'd1);
    tick();
    check("ldr_ex_mem_to_reg", 32'(ex_mem_to_reg), 32'd1);
    check("ldr_ex_reg_write", 32'(ex_reg_write), 32'd1);
    check("ldr_ex_alu_src", 32'(ex_alu_src), 32'd1);
    check("ldr_ex_mem_write", 32'(ex_mem_write), 32'd0);
    check("ldr_ex_alu_control", 32'(ex_alu_control), 32'd0);
    check("ldr_ex_sign_imm", ex_sign_imm, 32'h0000_0010);
    check("ldr_ex_pc_count", ex_pc_count, 32'h0000_0100);
    check("ldr_ex_rd1", ex_rd1, 32'h0000_0011);
    check("ldr_ex_rd2", ex_rd2, 32'h0000_0022);
    check("ldr_ex_rd", 32'(ex_rd), 32'd5);
    check("ldr_mem_not_yet", 32'(mem_mem_to_reg), 32'd0);

    // LDR executes, STR decodes.
    opcode        = 6'h21;
    id_pc_count   = 32'h0000_0104;
    id_rd         = 5'd6;
    ex_alu_result = 32'h0000_0110;
    ex_store_data = 32'h1234_5678;
    tick();
    check("ldr_mem_mem_to_reg", 32'(mem_mem_to_reg), 32'd1);
    check("ldr_mem_reg_write", 32'(mem_reg_write), 32'd1);
    check("ldr_mem_alu_result", mem_alu_result, 32'h0000_0110);
    check("ldr_mem_pc_count", mem_pc_count, 32'h0000_0100);
    check("ldr_mem_rd", 32'(mem_rd), 32'd5);
    check("str_ex_mem_write", 32'(ex_mem_write), 32'd1);
    check("str_ex_reg_write", 32'(ex_reg_write), 32'd0);
    check("str_ex_alu_src", 32'(ex_alu_src), 32'd1);

    // STR executes with store data, B decodes.
    ex_store_data = 32'hDEAD_BEEF;
    opcode        = 6'h30;
    #1;
    check("b_pc_src", 32'(pc_src), 32'd1);
    check("b_imm_src", 32'(imm_src), 32'd2);
    tick();
    check("str_mem_mem_write", 32'(mem_mem_write), 32'd1);
    check("str_mem_store_data", mem_store_data, 32'hDEAD_BEEF);
    check("str_mem_reg_write", 32'(mem_reg_write), 32'd0);
    check("str_mem_mem_to_reg", 32'(mem_mem_to_reg), 32'd0);
    check("b_ex_reg_write", 32'(ex_reg_write), 32'd0);
    check("b_ex_alu_src", 32'(ex_alu_src), 32'd0);

    // Opcode table: combinational outputs, then ID/EX control a cycle later.
    for (int i = 0; i < 16; i++) begin
      opcode = vecs[i].op;
      #1;
      check($sformatf("op%02h_pc_src", vecs[i].op), 32'(pc_src), 32'(vecs[i].ps));
      check($sformatf("op%02h_imm_src", vecs[i].op), 32'(imm_src), 32'(vecs[i].is));
      tick();
      check($sformatf("op%02h_ctrl", vecs[i].op),
            {23'd0, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_control},
            {23'd0, vecs[i].m2r, vecs[i].mw, vecs[i].as, vecs[i].rw, vecs[i].alu});
    end

    // Reset in flight discards everything.
    opcode      = 6'h20;
    id_pc_count = 32'h0000_0300;
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    check_all_regs_zero("midop_reset");
    #1 rst = 1'b1;
    opcode      = 6'h04;
    id_pc_count = 32'h0000_0400;
    tick();
    check("post_reset_ex_alu", 32'(ex_alu_control), 32'd3);
    check("post_reset_ex_pc", ex_pc_count, 32'h0000_0400);
    check("post_reset_mem_zero", mem_pc_count, 32'h0);

`ifdef PIPE_FLUSH_EN
    // Flush zeroes ID/EX control but data advances; EX/MEM still loads.
    opcode      = 6'h01;
    id_pc_count = 32'h0000_0200;
    flush       = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_ex_reg_write", 32'(ex_reg_write), 32'd0);
    check("flush_ex_alu_control", 32'(ex_alu_control), 32'd0);
    check("flush_ex_pc_count", ex_pc_count, 32'h0000_0200);
    check("flush_mem_reg_write", 32'(mem_reg_write), 32'd1);
    tick();
    check("after_flush_ex_reg_write", 32'(ex_reg_write), 32'd1);
    check("after_flush_mem_reg_write", 32'(mem_reg_write), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
